// File: rtl/relu_bound_if.sv
// Lane-parallel ReLU-N datapath bundle: request side (in_valid/in/bound) and
// registered result side (out_valid/out).
interface relu_bound_if #(
    parameter int W     = 8,
    parameter int LANES = 1
);
    logic                     in_valid;
    logic [LANES*W-1:0]       in;
    logic                     bound_en;
    logic [W-2:0]             bound;
    logic                     out_valid;
    logic [LANES*(W-1)-1:0]   out;

    modport master (
        output in_valid, in, bound_en, bound,
        input  out_valid, out
    );

    modport slave (
        input  in_valid, in, bound_en, bound,
        output out_valid, out
    );
endinterface

// File: rtl/relu_bound.sv
// Registered lane-parallel ReLU with optional shared upper clamp (ReLU-N).
// Each signed W-bit lane becomes an unsigned (W-1)-bit result one clock later.
module relu_bound #(
    parameter int W     = 8,
    parameter int LANES = 1
) (
    input  logic         clk,
    input  logic         n_reset,
    relu_bound_if.slave  bus
);
    logic [LANES*(W-1)-1:0] nxt;
    logic [W-1:0]           x;

    // Sign test first; the clamp compare is unsigned on the low W-1 bits.
    always_comb begin
        nxt = '0;
        x   = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            x = bus.in[k*W +: W];
            if (x[W-1]) begin
                nxt[k*(W-1) +: (W-1)] = '0;
            end else if (bus.bound_en && (x[W-2:0] > bus.bound)) begin
                nxt[k*(W-1) +: (W-1)] = bus.bound;
            end else begin
                nxt[k*(W-1) +: (W-1)] = x[W-2:0];
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            bus.out_valid <= 1'b0;
            bus.out       <= '0;
        end else begin
            bus.out_valid <= bus.in_valid;
            bus.out       <= nxt;
        end
    end
endmodule

// File: tb/tb_relu_bound.sv
// Scoreboard bench for relu_bound in three shapes: 8x1, 8x4 and 16x2 lanes.
module tb_relu_bound;
    logic clk;
    logic n_reset;

    relu_bound_if #(.W(8),  .LANES(1)) if0 ();
    relu_bound_if #(.W(8),  .LANES(4)) if1 ();
    relu_bound_if #(.W(16), .LANES(2)) if2 ();

    relu_bound #(.W(8),  .LANES(1)) dut0 (.clk(clk), .n_reset(n_reset), .bus(if0.slave));
    relu_bound #(.W(8),  .LANES(4)) dut1 (.clk(clk), .n_reset(n_reset), .bus(if1.slave));
    relu_bound #(.W(16), .LANES(2)) dut2 (.clk(clk), .n_reset(n_reset), .bus(if2.slave));

    typedef struct {
        logic        v;
        logic [63:0] d;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t me;

    int checks = 0;
    int errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: ReLU, then clamp to bound when enabled.
    function automatic int relu_ref(input int x, input int be, input int b);
        if (x < 0) return 0;
        if (be != 0 && x > b) return b;
        return x;
    endfunction

    function automatic void build(input int w, input int lanes, input int xs[4],
                                  input int be, input int b,
                                  output logic [63:0] pin, output logic [63:0] pexp);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        pin  = '0;
        pexp = '0;
        for (int k = 0; k < lanes; k++) begin
            pin  |= (64'(longint'(xs[k])) & mask) << (k*w);
            pexp |= 64'(relu_ref(xs[k], be, b)) << (k*(w-1));
        end
    endfunction

    task automatic rnd(input int w, input int lanes, output logic v, output int xs[4],
                       output int be, output int b);
        v  = 1'($urandom_range(0, 1));
        be = int'($urandom_range(0, 1));
        b  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, (1 << (w-1)) - 1));
        for (int k = 0; k < 4; k++)
            xs[k] = (k < lanes) ? int'($urandom_range(0, (1 << w) - 1)) - (1 << (w-1)) : 0;
    endtask

    task automatic drv0(input logic v, input int xs[4], input int be, input int b);
        logic [63:0] pi, pe;
        exp_t e;
        build(8, 1, xs, be, b, pi, pe);
        if0.in_valid = v;
        if0.in       = pi[7:0];
        if0.bound_en = (be != 0);
        if0.bound    = 7'(b);
        e.v = v;
        e.d = pe;
        q0.push_back(e);
    endtask

    task automatic drv1(input logic v, input int xs[4], input int be, input int b);
        logic [63:0] pi, pe;
        exp_t e;
        build(8, 4, xs, be, b, pi, pe);
        if1.in_valid = v;
        if1.in       = pi[31:0];
        if1.bound_en = (be != 0);
        if1.bound    = 7'(b);
        e.v = v;
        e.d = pe;
        q1.push_back(e);
    endtask

    task automatic drv2(input logic v, input int xs[4], input int be, input int b);
        logic [63:0] pi, pe;
        exp_t e;
        build(16, 2, xs, be, b, pi, pe);
        if2.in_valid = v;
        if2.in       = pi[31:0];
        if2.bound_en = (be != 0);
        if2.bound    = 15'(b);
        e.v = v;
        e.d = pe;
        q2.push_back(e);
    endtask

    // One cycle: directed dut0 stimulus, random traffic on the wider shapes.
    task automatic cyc(input logic v0, input int x0, input int be0, input int b0);
        int   xs[4];
        logic v;
        int   be, b;
        @(negedge clk);
        xs = '{x0, 0, 0, 0};
        drv0(v0, xs, be0, b0);
        rnd(8, 4, v, xs, be, b);
        drv1(v, xs, be, b);
        rnd(16, 2, v, xs, be, b);
        drv2(v, xs, be, b);
    endtask

    task automatic dir_wide();
        int xs1[4];
        int xs2[4];
        xs1 = '{64, -1, 127, -128};
        xs2 = '{-32768, 32767, 0, 0};
        drv1(1'b1, xs1, 0, 0);
        drv2(1'b1, xs2, 1, 1000);
    endtask

    always @(posedge clk) begin
        #1;
        if (n_reset) begin
            if (q0.size() > 0) begin
                me = q0.pop_front();
                chk("d0_valid", 64'(if0.out_valid), 64'(me.v));
                chk("d0_out",   64'(if0.out), me.d);
            end
            if (q1.size() > 0) begin
                me = q1.pop_front();
                chk("d1_valid", 64'(if1.out_valid), 64'(me.v));
                chk("d1_out",   64'(if1.out), me.d);
            end
            if (q2.size() > 0) begin
                me = q2.pop_front();
                chk("d2_valid", 64'(if2.out_valid), 64'(me.v));
                chk("d2_out",   64'(if2.out), me.d);
            end
        end
    end

    initial begin
        int   xs[4];
        logic v;
        int   be, b;

        n_reset = 1'b0;
        if0.in_valid = 1'b0; if0.in = '0; if0.bound_en = 1'b0; if0.bound = '0;
        if1.in_valid = 1'b0; if1.in = '0; if1.bound_en = 1'b0; if1.bound = '0;
        if2.in_valid = 1'b0; if2.in = '0; if2.bound_en = 1'b0; if2.bound = '0;

        #3;
        chk("rst_d0_valid", 64'(if0.out_valid), 64'd0);
        chk("rst_d0_out",   64'(if0.out), 64'd0);
        chk("rst_d1_out",   64'(if1.out), 64'd0);
        chk("rst_d2_out",   64'(if2.out), 64'd0);
        @(negedge clk);
        #2 n_reset = 1'b1;

        // Full signed sweep, plain ReLU; wide shapes get their directed vectors first.
        @(negedge clk);
        xs = '{-128, 0, 0, 0};
        drv0(1'b1, xs, 0, 0);
        dir_wide();
        for (int i = -127; i <= 127; i++) cyc(1'b1, i, 0, 0);

        // Single-cycle valid pulse.
        cyc(1'b0, 0, 0, 0);
        cyc(1'b1, 5, 0, 0);
        cyc(1'b0, 5, 0, 0);

        // Clamp at 6, then clamp at 0.
        cyc(1'b1, 100, 1, 6);
        cyc(1'b1, 6,   1, 6);
        cyc(1'b1, 3,   1, 6);
        cyc(1'b1, -7,  1, 6);
        cyc(1'b1, 127, 1, 0);
        cyc(1'b1, 1,   1, 0);
        cyc(1'b1, 50,  1, 0);

        for (int i = 0; i < 300; i++) begin
            rnd(8, 1, v, xs, be, b);
            cyc(v, xs[0], be, b);
        end

        // Asynchronous reset between edges with live inputs, then release.
        @(negedge clk);
        xs = '{42, 0, 0, 0};
        drv0(1'b1, xs, 0, 0);
        dir_wide();
        #2 n_reset = 1'b0;
        q0.delete();
        q1.delete();
        q2.delete();
        #1;
        chk("async_d0_valid", 64'(if0.out_valid), 64'd0);
        chk("async_d0_out",   64'(if0.out), 64'd0);
        chk("async_d1_valid", 64'(if1.out_valid), 64'd0);
        chk("async_d2_out",   64'(if2.out), 64'd0);
        @(posedge clk);
        #1;
        chk("held_d0_valid", 64'(if0.out_valid), 64'd0);
        chk("held_d0_out",   64'(if0.out), 64'd0);
        @(negedge clk);
        #2 n_reset = 1'b1;
        drv0(1'b1, xs, 0, 0);
        dir_wide();

        for (int i = 0; i < 50; i++) begin
            rnd(8, 1, v, xs, be, b);
            cyc(v, xs[0], be, b);
        end

        @(negedge clk);
        @(posedge clk);
        #2;
        chk("drain", 64'(q0.size() + q1.size() + q2.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
